fft_unload: RTL



---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_unload_fifo.sv | 58 +++++
 rtl/fft_unload.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result unloader.
// Holds the default word geometry, the FIFO depth and the unload state type.
package fft_pkg;

    localparam int WORD_SIZE_DEF = 74;
    localparam int HALF_WORD     = WORD_SIZE_DEF / 2;
    localparam int FFT_SIZE_DEF  = 8;
    localparam int FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } unload_state_t;

endpackage

// File: rtl/fft_unload_fifo.sv
// sync_fifo: small synchronous FIFO that accepts two words per cycle and
// pops one. Ports: clk_i, rst_i (sync, active-high), wr2_i + wdata_a_i /
// wdata_b_i (pair write, A first), rd_i (pop), head_o, valid_o, count_o.
module sync_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr2_i,
    input  logic [WIDTH-1:0]           wdata_a_i,
    input  logic [WIDTH-1:0]           wdata_b_i,
    input  logic                       rd_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        count_d = count_q;
        if (wr2_i) count_d = count_d + CW'(2);
        if (rd_i)  count_d = count_d - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr2_i) wptr_q <= wptr_q + AW'(2);
            if (rd_i)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr2_i) begin
            mem_q[wptr_q]          <= wdata_a_i;
            mem_q[wptr_q + AW'(1)] <= wdata_b_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fft_unload.sv
// fft_unload: reads FFT results pairwise from a dual-port RAM and streams
// them out in address order over valid/ready. Ports: i_CLK, i_RST, i_start,
// i_rddata_A/B, i_ready in; o_rden, o_rdaddr_A/B, o_data, o_valid, o_last,
// o_busy, o_done out.
module fft_unload
    import fft_pkg::*;
#(
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int FFT_SIZE   = FFT_SIZE_DEF,
    parameter int MEM_OFFSET = FFT_SIZE,
    parameter int ADDR_SIZE  = $clog2(2 * FFT_SIZE)
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_start,
    input  logic [WORD_SIZE-1:0] i_rddata_A,
    input  logic [WORD_SIZE-1:0] i_rddata_B,
    input  logic                 i_ready,
    output logic                 o_rden,
    output logic [ADDR_SIZE-1:0] o_rdaddr_A,
    output logic [ADDR_SIZE-1:0] o_rdaddr_B,
    output logic [WORD_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int PW = $clog2(FFT_SIZE / 2) + 1;
    localparam int WW = $clog2(FFT_SIZE) + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    unload_state_t    state_q, state_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             inflight_q;

    logic [CW-1:0]    fifo_count;
    logic             fifo_valid;
    logic [WORD_SIZE-1:0] fifo_head;
    logic [CW:0]      occ;
    logic             issue;
    logic             xfer;
    logic             last;
    logic [ADDR_SIZE-1:0] base;

    // Occupancy includes the pair still in the RAM pipeline, so a read is
    // only issued when both of its words are guaranteed a slot.
    assign occ   = (CW+1)'(fifo_count) + (inflight_q ? (CW+1)'(2) : '0);
    assign issue = (state_q == ST_READ) &&
                   (occ <= (CW+1)'(FIFO_DEPTH - 2));
    assign xfer  = fifo_valid & i_ready;
    assign last  = fifo_valid & (wcnt_q == WW'(FFT_SIZE - 1));
    assign base  = ADDR_SIZE'(MEM_OFFSET) + ADDR_SIZE'({p_q, 1'b0});

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        wcnt_d  = wcnt_q;
        if (xfer) wcnt_d = wcnt_q + WW'(1);
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_READ;
                    p_d     = '0;
                    wcnt_d  = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    p_d = p_q + PW'(1);
                    if (p_q == PW'(FFT_SIZE / 2 - 1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            p_q        <= '0;
            wcnt_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            wcnt_q     <= wcnt_d;
            inflight_q <= issue;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_CLK),
        .rst_i     (i_RST),
        .wr2_i     (inflight_q),
        .wdata_a_i (i_rddata_A),
        .wdata_b_i (i_rddata_B),
        .rd_i      (xfer),
        .head_o    (fifo_head),
        .valid_o   (fifo_valid),
        .count_o   (fifo_count)
    );

    assign o_rden     = issue;
    assign o_rdaddr_A = issue ? base : '0;
    assign o_rdaddr_B = issue ? base + ADDR_SIZE'(1) : '0;
    assign o_data     = fifo_head;
    assign o_valid    = fifo_valid;
    assign o_last     = last;
    assign o_busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign o_done     = (state_q == ST_DONE);

endmodule
